// File: rtl/channel_pkg.sv
// Shared types and helpers for the channel_mac multiply/accumulate channel.
package channel_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROW   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/channel_out_fifo.sv
// First-word fall-through result FIFO with occupancy count; head reads 0 when empty.
module channel_out_fifo
  import channel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_rd)   r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_rd);
    end
  end

  // Upstream credit accounting guarantees a free slot for every push.
  always @(posedge i_clk) begin
    if (i_rst_n) assert (!(i_push && o_full));
  end

endmodule

// File: rtl/channel_mac.sv
// Lock-step operand pop, multiply, optional row accumulate, credit-managed result FIFO.
// Define CHANNEL_MAC_SAT_EN for a saturating accumulator and the o_acc_ovf pulse.
//   state   | meaning
//   S_IDLE  | waiting for the first operand pair of a row
//   S_ROW   | issuing the remaining elements of the row
//   S_DRAIN | row fully issued, waiting for its last product to be pushed
module channel_mac
  import channel_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ROW_LEN_W = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ROW_LEN_W-1:0] i_row_len,
  input  logic                 i_acc_mode,
  input  logic [DATA_W-1:0]    i_matrix_val,
  input  logic                 i_matrix_val_empty,
  output logic                 o_matrix_val_rd_en,
  input  logic [DATA_W-1:0]    i_vec_val,
  input  logic                 i_vec_val_empty,
  output logic                 o_vec_val_rd_en,
  input  logic                 i_mult_rd_en,
  output logic                 o_mult_empty,
  output logic                 o_mult_full,
  output logic [ACC_W-1:0]     o_mult_out,
`ifdef CHANNEL_MAC_SAT_EN
  output logic                 o_acc_ovf,
`endif
  output logic                 o_busy
);
  localparam int PROD_W = prod_w(DATA_W);
  localparam int CNT_W  = clog2(OUT_DEPTH + 1);

  state_t                 r_state, w_state_nxt;
  logic [ROW_LEN_W-1:0]   r_len, r_cnt, w_len_nxt, w_cnt_nxt;
  logic                   r_mode, w_mode_nxt, r_live;
  logic [CNT_W-1:0]       r_resv, w_fifo_count;
  logic                   w_start, w_operands, w_need_credit, w_credit_ok;
  logic                   w_issue, w_first, w_last, w_push, w_row_done, w_load;
  logic                   r_v1, r_first1, r_last1, r_mode1;
  logic                   r_v2, r_first2, r_last2, r_mode2;
  logic [PROD_W-1:0]      r_prod;
  logic [ACC_W-1:0]       r_acc, w_prod_ext, w_sum;

  assign w_operands  = r_live & ~i_matrix_val_empty & ~i_vec_val_empty;
  assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_resv}) < (CNT_W+1)'(OUT_DEPTH);
  assign w_row_done  = r_v2 & r_last2;
  assign w_push      = r_v2 & (~r_mode2 | r_last2);

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_mode_nxt    = r_mode;
    w_start       = 1'b0;
    w_need_credit = 1'b0;
    w_issue       = 1'b0;
    w_first       = 1'b0;
    w_last        = 1'b0;
    unique case (r_state)
      S_IDLE:  w_start = 1'b1;
      S_ROW: begin
        w_need_credit = ~r_mode;
        w_issue       = w_operands & (r_mode | w_credit_ok);
        if (w_issue) begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_last    = (w_cnt_nxt == r_len);
          if (w_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_row_done) begin
          w_state_nxt = S_IDLE;
          w_start     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The first issue of every row reserves a slot in either mode.
    if (w_start) begin
      w_need_credit = 1'b1;
      w_issue       = w_operands & w_credit_ok;
      if (w_issue) begin
        w_len_nxt   = (i_row_len == '0) ? ROW_LEN_W'(1) : i_row_len;
        w_mode_nxt  = i_acc_mode;
        w_cnt_nxt   = ROW_LEN_W'(1);
        w_first     = 1'b1;
        w_last      = (i_row_len <= ROW_LEN_W'(1));
        w_state_nxt = w_last ? S_DRAIN : S_ROW;
      end
    end
  end

  assign o_matrix_val_rd_en = w_issue;
  assign o_vec_val_rd_en    = w_issue;
  assign o_busy             = (r_state != S_IDLE) | r_v1 | r_v2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_live   <= 1'b0;
      r_resv   <= '0;
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_mode1  <= 1'b0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_mode2  <= 1'b0;
      r_prod   <= '0;
      r_acc    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode   <= w_mode_nxt;
      r_live   <= 1'b1;
      r_resv   <= r_resv + CNT_W'(w_issue & w_need_credit) - CNT_W'(w_push);
      r_v1     <= w_issue;
      r_first1 <= w_first;
      r_last1  <= w_last;
      r_mode1  <= w_mode_nxt;
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_mode2  <= r_mode1;
      r_prod   <= PROD_W'(i_matrix_val) * PROD_W'(i_vec_val);
      if (r_v2) r_acc <= w_push ? '0 : w_sum;
    end
  end

  assign w_prod_ext = ACC_W'(r_prod);
  assign w_load     = r_first2 | ~r_mode2;

`ifdef CHANNEL_MAC_SAT_EN
  logic [ACC_W:0] w_add;
  logic           w_sat_now, r_sat, r_acc_ovf;

  assign w_add     = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sat_now = ~w_load & w_add[ACC_W];
  assign w_sum     = w_load ? w_prod_ext : (w_add[ACC_W] ? '1 : w_add[ACC_W-1:0]);
  assign o_acc_ovf = r_acc_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat     <= 1'b0;
      r_acc_ovf <= 1'b0;
    end else begin
      r_acc_ovf <= w_push & (r_sat | w_sat_now);
      if (w_push)    r_sat <= 1'b0;
      else if (r_v2) r_sat <= r_sat | w_sat_now;
    end
  end
`else
  assign w_sum = w_load ? w_prod_ext : r_acc + w_prod_ext;
`endif

  channel_out_fifo #(
    .WIDTH (ACC_W),
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_sum),
    .i_pop   (i_mult_rd_en),
    .o_dout  (o_mult_out),
    .o_empty (o_mult_empty),
    .o_full  (o_mult_full),
    .o_count (w_fifo_count)
  );

endmodule

// File: doc/channel_mac.md
Name: channel_mac

Overview:
- Parametrised successor of the single-product matrix/vector channel.
- Pops matrix and vector operands from two upstream FIFOs in lock-step and multiplies each pair.
- acc_mode=0: pushes each product to an internal output FIFO.
- acc_mode=1: accumulates row_len products into one dot product per row, then pushes it. Sits between the operand FIFOs and the reduction/write-back stage of the sparse MV engine.

Parameters:
- DATA_W, 8, operand width (unsigned).
- ROW_LEN_W, 8, width of row_len; rows of up to 2^ROW_LEN_W-1 elements.
- ACC_W, 32, accumulator and result width; must be >= 2*DATA_W.
- OUT_DEPTH, 8, output FIFO depth; power of two, >= 2.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- row_len, in, ROW_LEN_W, products per row; sampled at row start; 0 is treated as 1.
- acc_mode, in, 1, 0 = per-product output, 1 = row accumulate; sampled at row start.
- matrix_val, in, DATA_W, matrix operand; valid the cycle after matrix_val_rd_en.
- matrix_val_empty, in, 1, matrix FIFO empty.
- matrix_val_rd_en, out, 1, matrix FIFO pop.
- vec_val, in, DATA_W, vector operand; valid the cycle after vec_val_rd_en.
- vec_val_empty, in, 1, vector FIFO empty.
- vec_val_rd_en, out, 1, vector FIFO pop; always equal to matrix_val_rd_en.
- mult_rd_en, in, 1, output FIFO pop.
- mult_empty, out, 1, output FIFO empty.
- mult_full, out, 1, output FIFO full.
- mult_out, out, ACC_W, head of output FIFO (first-word fall-through).
- busy, out, 1, row in progress or pipeline non-empty.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_en outputs 0, mult_empty 1, mult_full 0, mult_out 0, busy 0.
  - FSM to S_IDLE; accumulator, counters and credits cleared.
  - In-flight products and FIFO contents discarded, including when reset lands mid-row.
- Issue:
  - issue = !matrix_val_empty & !vec_val_empty & credit_ok. Both rd_en are driven from issue in the same cycle.
  - rd_en depends only on the empty flags and registered state; there is no combinational path from mult_rd_en.
- Credits: one output slot is reserved per expected push.
  - acc_mode=1: reserved at the first issue of the row.
  - acc_mode=0: reserved at every issue.
  - credit_ok = (fifo_count + reserved < OUT_DEPTH), required only when the issue reserves a slot.
  - A slot is released on push. A pop frees its slot from the next cycle.
- FSM:
  - S_IDLE: on issue, latch row_len (0->1) and acc_mode, set elem_cnt=1. Go to S_DRAIN if the row length is 1, else S_ROW.
  - S_ROW: each issue increments elem_cnt. When elem_cnt reaches the latched row length, go to S_DRAIN.
  - S_DRAIN: no issue. When the last product is pushed, go to S_IDLE; a new row may issue in the same cycle.
  - row_len and acc_mode changes mid-row are ignored.
- Pipeline latency:
  - Issue in cycle T.
  - Operands captured and product registered at the end of T+1 (product width 2*DATA_W, zero-extended to ACC_W).
  - Accumulate/push at the end of T+2; result visible on mult_out, with mult_empty low, in T+3.
  - Back-to-back issue sustains one product per cycle.
- Accumulation:
  - The first product of a row loads the accumulator; later products add to it.
  - Arithmetic wraps modulo 2^ACC_W.
  - The last product's sum is pushed and the accumulator cleared.
- Output FIFO:
  - Pop while empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Push while full cannot occur because of credits; assert this in simulation.
- busy = (state != S_IDLE) | product pipeline valid.

Optional Feature:
- Macro CHANNEL_MAC_SAT_EN.
- Defined:
  - The accumulator saturates at 2^ACC_W-1 instead of wrapping.
  - Extra output port acc_ovf (1 bit) pulses high for one cycle with the push of any row that saturated.
  - acc_ovf resets to 0.
- Undefined: wrap-around arithmetic and no acc_ovf port.

Decomposition:
- channel_pkg:
  - FSM state enum (S_IDLE, S_ROW, S_DRAIN).
  - Function clog2 for counter widths.
  - Constant PROD_W = 2*DATA_W helper.
- One sub-module, channel_out_fifo:
  - Parametrised depth/width, first-word fall-through.
  - Provides count, empty and full.
  - Asynchronous active-low reset.

Test Plan:
- acc_mode=0, row_len=1; matrix=1 against vec 1,2,3,4,5,6,7,7; mult_rd_en=1 -> mult_out sequence 1,2,3,4,5,6,7,7; first result 3 cycles after first rd_en.
- acc_mode=1, row_len=8, same operands -> exactly one result, 35; busy falls after the push; a second row of 8 ones -> 8.
- OUT_DEPTH=4, acc_mode=0, 8 pairs available, mult_rd_en=0 -> exactly 4 issues, then mult_full=1 and rd_en stays 0; single pop -> exactly one further issue the cycle after.
- vec_val_empty held 1 with matrix data present -> neither rd_en asserts; deassert -> both assert in the same cycle.
- rst pulsed low mid-row after 3 of 8 elements -> all outputs at reset values immediately; the next full row of 8 ones yields 8, not 11.
- ACC_W=16, row_len=2, operands 255*255 twice -> 64514 without macro; 65535 with acc_ovf=1 for one cycle with CHANNEL_MAC_SAT_EN.
